// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the EX-stage integer divider.
// Holds the FSM state encodings and result-select codes.
package ex_div_unit_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic QUOTIENT  = 1'b0;
  localparam logic REMAINDER = 1'b1;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'b00,
    DIV_ST_CALC = 2'b01,
    DIV_ST_DONE = 2'b10
  } div_st_e;

endpackage

// File: rtl/ex_div_unit_if.sv
// EX <-> divider handshake: start/sign/sel/operands in, busy/valid/result out.
// master = EX stage side, slave = divider side.
interface ex_div_unit_if #(
  parameter int XLEN = 32
);
  logic            div_start;
  logic            div_sign;
  logic            div_res_sel;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_res_ack;
  logic            div_busy;
  logic            div_res_valid;
  logic [XLEN-1:0] div_result;

  modport master (
    output div_start, div_sign, div_res_sel,
    output div_dividend, div_divisor, div_res_ack,
    input  div_busy, div_res_valid, div_result
  );

  modport slave (
    input  div_start, div_sign, div_res_sel,
    input  div_dividend, div_divisor, div_res_ack,
    output div_busy, div_res_valid, div_result
  );
endinterface

// File: rtl/ex_div_unit_div_iter.sv
// One combinational restoring-division step.
// In: shifted partial remainder, divisor. Out: next remainder, quotient bit.
module ex_div_unit_div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_sh,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);

  logic [XLEN:0] diff;

  // rem_sh < 2*divisor, so the kept remainder always fits XLEN bits.
  always_comb begin
    diff    = rem_sh - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_nxt = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  end

endmodule

// File: rtl/ex_div_unit.sv
// RV32M DIV/DIVU/REM/REMU multi-cycle divider (clk, rst_n, pipe_flush, div_if.slave).
// Optional last-result cache enabled by macro DIV_RES_CACHE_EN.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pipe_flush,
  ex_div_unit_if.slave div_if
);

  div_st_e st, st_nxt;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  dvd_r;
  logic [XLEN-1:0]  dvs_r;
  logic [XLEN-2:0]  quo_r;
  logic [XLEN-1:0]  res_r;
  logic             sel_r;
  logic             neg_q_r;
  logic             neg_r_r;

  logic [XLEN-1:0] a, b;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            a_neg, b_neg;
  logic            by_zero, ovf, special;
  logic [XLEN-1:0] spec_res;
  logic            hit;
  logic [XLEN-1:0] hit_res;
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic            accept, last;

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_nxt;
  logic            q_bit;
  logic [XLEN-1:0] q_fin, r_fin;
  logic [XLEN-1:0] q_fix, r_fix;

  assign a = div_if.div_dividend;
  assign b = div_if.div_divisor;

  always_comb begin
    a_neg    = div_if.div_sign & a[XLEN-1];
    b_neg    = div_if.div_sign & b[XLEN-1];
    a_abs    = a_neg ? -a : a;
    b_abs    = b_neg ? -b : b;
    by_zero  = (b == '0);
    ovf      = div_if.div_sign
             & (a == {1'b1, {(XLEN-1){1'b0}}})
             & (b == '1);
    special  = by_zero | ovf;
    // Overflow quotient equals the dividend itself.
    if (div_if.div_res_sel == REMAINDER)
      spec_res = by_zero ? a : '0;
    else
      spec_res = by_zero ? '1 : a;
    fast     = special | hit;
    fast_res = special ? spec_res : hit_res;
  end

  assign accept = (st == DIV_ST_IDLE) & div_if.div_start & ~pipe_flush;
  assign last   = (cnt == CNT_W'(XLEN-1));

  assign rem_sh = {rem_r, dvd_r[XLEN-1]};

  ex_div_unit_div_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .rem_sh  (rem_sh),
    .divisor (dvs_r),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign q_fin = {quo_r, q_bit};
  assign r_fin = rem_nxt;
  assign q_fix = neg_q_r ? -q_fin : q_fin;
  assign r_fix = neg_r_r ? -r_fin : r_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= DIV_ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      DIV_ST_IDLE:
        if (div_if.div_start)
          st_nxt = fast ? DIV_ST_DONE : DIV_ST_CALC;
      DIV_ST_CALC:
        if (last) st_nxt = DIV_ST_DONE;
      DIV_ST_DONE:
        if (div_if.div_res_ack) st_nxt = DIV_ST_IDLE;
      default: st_nxt = DIV_ST_IDLE;
    endcase
    if (pipe_flush) st_nxt = DIV_ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      rem_r   <= '0;
      dvd_r   <= '0;
      dvs_r   <= '0;
      quo_r   <= '0;
      res_r   <= '0;
      sel_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (pipe_flush) begin
      cnt <= '0;
    end else if (accept) begin
      sel_r   <= div_if.div_res_sel;
      neg_q_r <= a_neg ^ b_neg;
      neg_r_r <= a_neg;
      dvd_r   <= a_abs;
      dvs_r   <= b_abs;
      rem_r   <= '0;
      quo_r   <= '0;
      cnt     <= '0;
      if (fast) res_r <= fast_res;
    end else if (st == DIV_ST_CALC) begin
      rem_r <= rem_nxt;
      dvd_r <= dvd_r << 1;
      quo_r <= q_fin[XLEN-2:0];
      cnt   <= cnt + CNT_W'(1);
      if (last)
        res_r <= (sel_r == REMAINDER) ? r_fix : q_fix;
    end
  end

`ifdef DIV_RES_CACHE_EN
  logic            c_vld;
  logic            c_s;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;
  logic            op_s_r;
  logic [XLEN-1:0] op_a_r, op_b_r;

  assign hit = c_vld & (c_a == a) & (c_b == b)
             & (c_s == div_if.div_sign);
  assign hit_res = (div_if.div_res_sel == REMAINDER) ? c_r : c_q;

  // Flush leaves the cache intact; only a completed divide updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld  <= 1'b0;
      c_s    <= 1'b0;
      c_a    <= '0;
      c_b    <= '0;
      c_q    <= '0;
      c_r    <= '0;
      op_s_r <= 1'b0;
      op_a_r <= '0;
      op_b_r <= '0;
    end else if (!pipe_flush) begin
      if (accept) begin
        op_s_r <= div_if.div_sign;
        op_a_r <= a;
        op_b_r <= b;
      end else if (st == DIV_ST_CALC && last) begin
        c_vld <= 1'b1;
        c_s   <= op_s_r;
        c_a   <= op_a_r;
        c_b   <= op_b_r;
        c_q   <= q_fix;
        c_r   <= r_fix;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  assign div_if.div_busy      = (st != DIV_ST_IDLE);
  assign div_if.div_res_valid = (st == DIV_ST_DONE);
  assign div_if.div_result    = res_r;

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Multi-cycle integer divider in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes ex_is_div_inst, ex_div_sign, ex_div_res_sel, ex_rs1 and ex_rs2; returns a quotient or remainder under a start/valid/ack handshake.
- EX holds its ready_go low while a division is outstanding, so the ID/EX register stalls via ex_allowin.
- Implements RV32M DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pipe_flush  in  1  pipeline flush; aborts any operation
- div_start  in  1  request; driven as EX valid AND ex_is_div_inst
- div_sign  in  1  1 = signed (DIV/REM), 0 = unsigned
- div_res_sel  in  1  `QUOTIENT / `REMAINDER
- div_dividend  in  XLEN  rs1 value
- div_divisor  in  XLEN  rs2 value
- div_res_ack  in  1  EX consumes the result (EX moving to MEM)
- div_busy  out  1  state != IDLE
- div_res_valid  out  1  result available; feeds EX ready_go
- div_result  out  XLEN  selected quotient or remainder

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; counter = 0; all internal registers = 0.
  - div_busy = 0, div_res_valid = 0, div_result = 0.
- States and transitions:
  - IDLE -> CALC, or IDLE -> DONE for special cases, on div_start.
  - CALC -> DONE after XLEN iterations.
  - DONE -> IDLE on div_res_ack.
- Start acceptance:
  - div_start is sampled only in IDLE and ignored in every other state.
  - On accept, latch sign, res_sel, the sign of each operand, and the absolute values of dividend and divisor (absolute only when div_sign = 1).
- Special cases, resolved at accept; state goes straight to DONE, div_res_valid rises 1 cycle after accept:
  - divisor == 0: quotient = all ones, remainder = dividend.
  - signed, dividend == 0x8000_0000, divisor == all ones: quotient = 0x8000_0000, remainder = 0.
- Normal path (restoring radix-2):
  - One quotient bit per CALC cycle, MSB first.
  - Each step: partial remainder (XLEN+1 bits) shifted left 1 with the next dividend bit; subtract the divisor if the result is non-negative; the quotient bit is the inverse of the borrow.
  - The counter increments each CALC cycle; at counter == XLEN-1 the next state is DONE.
  - Latency from the accept edge to div_res_valid = XLEN+1 cycles (33).
- Sign fix-up, on entry to DONE, registered:
  - Quotient is negated when signed and operand signs differ.
  - Remainder is negated when signed and the dividend is negative.
  - div_result holds the selected value, stable for the whole DONE state.
- DONE behaviour:
  - div_res_valid = 1 until div_res_ack.
  - Ack moves to IDLE; div_res_valid drops the next cycle.
  - A new div_start is accepted no earlier than the cycle after the ack.
- pipe_flush:
  - Any state -> IDLE on the next edge; div_res_valid = 0; the in-flight result is discarded.
  - Flush wins over a simultaneous div_start or div_res_ack.
- Reset mid-operation: immediate return to reset values, no residual state.
- Unsigned path: operands are used unmodified; no fix-up.
- div_res_ack outside DONE is ignored.

Optional Feature:
- Macro: DIV_RES_CACHE_EN.
- Defined:
  - Keep the last completed operands, sign, quotient and remainder, plus a cache-valid bit.
  - On accept, if the cache is valid and dividend, divisor and sign all match, go IDLE -> DONE and return the cached value selected by the new res_sel (1-cycle latency); this covers the DIV+REM pair idiom.
  - Cache-valid is cleared by reset; flush does not clear it.
  - The cache updates at every normal-path DONE entry.
- Undefined: no cache registers; every non-special division takes the full 33 cycles.

Decomposition:
- Shared defines.v additions: DIV_ST_IDLE / DIV_ST_CALC / DIV_ST_DONE (2-bit encodings).
- Existing `QUOTIENT / `REMAINDER, `XLEN, `ZEROWORD, `FLUSH, `DFF_RST_ENABLE and `RST_EDGE are reused.
- One sub-module, div_iter: purely combinational single restoring step, (partial remainder, divisor) -> (next remainder, quotient bit).

Test Plan:
- Unsigned 100 / 7, res_sel = QUOTIENT -> div_res_valid rises 33 cycles after accept, div_result = 14; repeat with REMAINDER -> 2.
- Signed -7 / 2 -> quotient 0xFFFF_FFFD (-3); remainder 0xFFFF_FFFF (-1).
- Divide by zero, dividend 0x1234 -> 1-cycle latency, quotient 0xFFFF_FFFF, remainder 0x1234.
- Signed 0x8000_0000 / 0xFFFF_FFFF -> 1 cycle, quotient 0x8000_0000, remainder 0.
- Flush at CALC cycle 10, with div_start asserted the same cycle -> next cycle IDLE, div_busy = 0, div_res_valid = 0; a following start of 9/3 returns 3 after 33 cycles.
- Hold div_res_ack low 5 cycles in DONE -> result and valid stable throughout; an ignored div_start during DONE does not change the result. With DIV_RES_CACHE_EN: DIV then REM of 100/7 -> REM returns 2 after 1 cycle.
